// File: rtl/stack_access_unit.sv
// Stack bus-cycle sequencer for the 6502 control unit: multi-byte pushes and pulls
// in the stack page, driving the stack pointer's inc/dec strobes alongside each cycle.
module stack_access_unit #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_pull,
  input  logic [1:0]  count,
  input  logic [23:0] push_data,
  input  logic [7:0]  sp_value,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [23:0] pull_data
);

  typedef enum logic [2:0] {IDLE, PUSH, PULL_INC, PULL_READ, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  remaining;
  logic [1:0]  total;
  logic [23:0] data_buf;
  logic [1:0]  pull_idx;

  // Highest remaining byte goes out first, so BRK pushes PCH, PCL, P in that order.
  function automatic logic [7:0] push_byte(input logic [23:0] d, input logic [1:0] n);
    case (n)
      2'd3:    push_byte = d[23:16];
      2'd2:    push_byte = d[15:8];
      default: push_byte = d[7:0];
    endcase
  endfunction

  // Pulled bytes fill from the low end: first byte read lands in [7:0].
  assign pull_idx = total - remaining;

  // State, byte counter, latched request and pull result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= 2'd0;
      total     <= 2'd0;
      data_buf  <= 24'h000000;
      pull_data <= 24'h000000;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            total     <= count;
            remaining <= count;
            data_buf  <= push_data;
            if (op_pull) begin
              pull_data <= 24'h000000;
            end
          end
        end
        PUSH: begin
          if (mem_ready) begin
            remaining <= remaining - 2'd1;
          end
        end
        PULL_READ: begin
          if (mem_ready) begin
            remaining <= remaining - 2'd1;
            case (pull_idx)
              2'd0:    pull_data[7:0]   <= mem_rdata;
              2'd1:    pull_data[15:8]  <= mem_rdata;
              default: pull_data[23:16] <= mem_rdata;
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and bus/strobe outputs; strobes fire on the accepting edge itself.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 8'h00;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count == 2'd0) begin
            state_next = DONE;
          end else if (op_pull) begin
            state_next = PULL_INC;
          end else begin
            state_next = PUSH;
          end
        end else begin
          state_next = IDLE;
        end
      end
      PUSH: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, sp_value};
        mem_wdata = push_byte(data_buf, remaining);
        if (mem_ready) begin
          sp_dec = 1'b1;
          if (remaining == 2'd1) begin
            state_next = DONE;
          end else begin
            state_next = PUSH;
          end
        end else begin
          state_next = PUSH;
        end
      end
      PULL_INC: begin
        busy       = 1'b1;
        sp_inc     = 1'b1;
        state_next = PULL_READ;
      end
      PULL_READ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {STACK_PAGE, sp_value};
        if (mem_ready) begin
          if (remaining == 2'd1) begin
            state_next = DONE;
          end else begin
            sp_inc     = 1'b1;
            state_next = PULL_READ;
          end
        end else begin
          state_next = PULL_READ;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stack_access_unit.sv
// Bench for stack_access_unit: a stack-page memory and stack pointer model surround the
// DUT; expected bus cycles and completions are queued and checked by a separate monitor.
module tb_stack_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_pull;
  logic [1:0]  count;
  logic [23:0] push_data;
  logic [7:0]  sp_value;
  logic        sp_inc, sp_dec;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        busy, done;
  logic [23:0] pull_data;

  logic        sp_load;
  logic [7:0]  sp_load_val;
  logic [7:0]  mem [256];

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit          is_done;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          chk_pd;
    logic [23:0] pdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  stack_access_unit #(.STACK_PAGE(8'h01)) dut (
    .clk(clk), .reset(reset), .start(start), .op_pull(op_pull), .count(count),
    .push_data(push_data), .sp_value(sp_value), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .pull_data(pull_data)
  );

  always #5 clk = ~clk;

  // Stack pointer register owned by the surrounding datapath.
  always @(posedge clk) begin
    if (sp_load) sp_value <= sp_load_val;
    else if (!reset) begin
      if (sp_inc) sp_value <= sp_value + 8'd1;
      else if (sp_dec) sp_value <= sp_value - 8'd1;
    end
  end

  // Stack page memory.
  always @(posedge clk) begin
    if (!reset && mem_req && mem_we && mem_ready) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected bus cycles and completions as the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      if (sp_inc || sp_dec) chk("strobe_exclusive", {63'd0, sp_inc & sp_dec}, 64'd0);
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          chk("unexpected_bus_cycle", {48'd0, mem_addr}, 64'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_addr", {48'd0, mem_addr}, {48'd0, mon_e.addr});
          chk("bus_we", {63'd0, mem_we}, {63'd0, mon_e.we});
          if (mon_e.we) chk("bus_wdata", {56'd0, mem_wdata}, {56'd0, mon_e.data});
        end
      end
      if (done) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.chk_pd) chk("pull_data", {40'd0, pull_data}, {40'd0, mon_e.pdata});
        end
      end
    end
  end

  task automatic load_sp(input logic [7:0] v);
    @(posedge clk); #1;
    sp_load = 1'b1; sp_load_val = v;
    @(posedge clk); #1;
    sp_load = 1'b0;
  endtask

  task automatic run_op(input bit pull, input logic [1:0] cnt, input logic [23:0] pd,
                        input int stall, input bit poke, input int exp_lat,
                        input logic [7:0] exp_sp, input bit chk_pd, input logic [23:0] exp_pd);
    exp_t e;
    logic [7:0] sp0;
    int lat;
    bit got;
    sp0 = sp_value;
    for (int k = 0; k < int'(cnt); k++) begin
      e.is_done = 1'b0; e.we = !pull; e.chk_pd = 1'b0; e.pdata = 24'h0;
      e.addr = pull ? {8'h01, sp0 + 8'(k + 1)} : {8'h01, sp0 - 8'(k)};
      e.data = pd[8*(int'(cnt) - 1 - k) +: 8];
      exp_q.push_back(e);
    end
    e.is_done = 1'b1; e.we = 1'b0; e.addr = 16'h0; e.data = 8'h0;
    e.chk_pd = chk_pd; e.pdata = exp_pd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; op_pull = pull; count = cnt; push_data = pd;
    mem_ready = (stall == 0);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (lat == stall + 1) mem_ready = 1'b1;
      if (poke && lat == 2) begin
        start = 1'b1; op_pull = 1'b0; count = 2'd1; push_data = 24'h0000EE;
      end
      @(negedge clk);
      if (lat == 1 && cnt != 2'd0) chk("busy_after_start", {63'd0, busy}, 64'd1);
      if (lat <= stall) begin
        chk("stall_hold", {45'd0, mem_req, sp_dec, mem_addr, mem_wdata},
            {45'd0, 1'b1, 1'b0, 8'h01, sp0, pd[8*(int'(cnt) - 1) +: 8]});
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("sp_final", {56'd0, sp_value}, {56'd0, exp_sp});
    if (cnt == 2'd0) chk("noop_quiet", {61'd0, mem_req, sp_inc, sp_dec}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_pull = 1'b0; count = 2'd0; push_data = 24'h0;
    mem_ready = 1'b1; sp_load = 1'b1; sp_load_val = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, mem_req, mem_we, sp_inc, sp_dec, mem_wdata, mem_addr, pull_data},
        64'd0);
    #1 reset = 1'b0; sp_load = 1'b0;

    load_sp(8'hFF);
    run_op(1'b0, 2'd1, 24'h0000A5, 0, 1'b0, 2, 8'hFE, 1'b0, 24'h0);       // push 1
    load_sp(8'hFD);
    run_op(1'b0, 2'd2, 24'h001234, 0, 1'b0, 3, 8'hFB, 1'b0, 24'h0);       // JSR
    load_sp(8'hFD);
    run_op(1'b0, 2'd3, 24'h123424, 0, 1'b0, 4, 8'hFA, 1'b0, 24'h0);       // preload RTI frame
    run_op(1'b1, 2'd3, 24'h123424, 0, 1'b1, 5, 8'hFD, 1'b1, 24'h123424);  // RTI, start poked
    run_op(1'b0, 2'd2, 24'h00BEEF, 3, 1'b0, 6, 8'hFB, 1'b0, 24'h0);       // stalled push
    load_sp(8'h00);
    run_op(1'b0, 2'd1, 24'h00005A, 0, 1'b0, 2, 8'hFF, 1'b0, 24'h0);       // wrap push
    run_op(1'b1, 2'd1, 24'h00005A, 0, 1'b0, 3, 8'h00, 1'b1, 24'h00005A);  // wrap pull
    run_op(1'b0, 2'd0, 24'h0000AA, 0, 1'b0, 1, 8'h00, 1'b1, 24'h00005A);  // no-op push
    run_op(1'b1, 2'd0, 24'h000000, 0, 1'b0, 1, 8'h00, 1'b1, 24'h000000);  // no-op pull clears

    // Reset while the second byte of a 3-byte pull is on the bus.
    load_sp(8'hFA);
    mon_e.is_done = 1'b0; mon_e.we = 1'b0; mon_e.addr = 16'h01FB; mon_e.data = 8'h0;
    mon_e.chk_pd = 1'b0; mon_e.pdata = 24'h0;
    exp_q.push_back(mon_e);
    @(posedge clk); #1;
    start = 1'b1; op_pull = 1'b1; count = 2'd3; mem_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pull_in_progress", {63'd0, busy}, 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_midpull_outputs", {busy, done, mem_req, mem_we, sp_inc, sp_dec, mem_wdata, mem_addr, pull_data},
        64'd0);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_strobe_after_reset", {61'd0, sp_inc, sp_dec, busy}, 64'd0);
    end
    chk("sp_after_abort", {56'd0, sp_value}, 64'hFC);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/stack_access_unit.md
Name: stack_access_unit

Overview:
Sequencer that performs 6502 stack bus cycles on behalf of the control unit: multi-byte pushes (PHA/PHP/JSR/BRK/IRQ) and pulls (PLA/PLP/RTS/RTI).
- Reads the current stack pointer value and drives the address bus in the stack page.
- Drives the stack pointer's inc/dec strobes: post-decrement on push, pre-increment on pull.
- Sits between the control unit, the stack pointer register and the memory bus arbiter.

Parameters:
STACK_PAGE, 8'h01, high address byte of all stack accesses.

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  synchronous, active-high
start  in  1  request pulse; sampled only in IDLE
op_pull  in  1  0 = push, 1 = pull; sampled with start
count  in  2  bytes to transfer, 1..3; 0 = no-op
push_data  in  24  push bytes; sampled with start
sp_value  in  8  current stack pointer output
sp_inc  out  1  stack pointer increment strobe
sp_dec  out  1  stack pointer decrement strobe
mem_addr  out  16  bus address
mem_wdata  out  8  write data
mem_we  out  1  write enable
mem_req  out  1  bus cycle valid
mem_rdata  in  8  read data
mem_ready  in  1  bus cycle completes this edge when 1
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
pull_data  out  24  assembled pull result; valid from done until next start

Behaviour:
- Reset: state IDLE; all outputs 0, including pull_data.
- Reset mid-operation: immediately IDLE; no further strobes; a partially done transfer is abandoned. The bus cycle in flight is dropped.
- States: IDLE, PUSH, PULL_INC, PULL_READ, DONE.
- IDLE:
  - start=1 latches op_pull, count, push_data.
  - Byte counter := count; pull_data is cleared when op_pull=1.
  - Next state: count=0 -> DONE; op_pull=0 -> PUSH; op_pull=1 -> PULL_INC.
  - start while not IDLE is ignored entirely.
- Push byte order:
  - count=3: push_data[23:16], [15:8], [7:0].
  - count=2: [15:8], [7:0].
  - count=1: [7:0].
  - Example: BRK pushes PCH, PCL, P.
- PUSH:
  - Drives mem_req=1, mem_we=1, mem_addr={STACK_PAGE, sp_value}, mem_wdata=current byte.
  - On an edge with mem_ready=1: sp_dec=1 in that same cycle and the counter decrements. When the last byte is accepted -> DONE.
  - mem_ready=0: address and data held; sp_dec=0.
- PULL_INC: one cycle, no bus request, sp_inc=1, then -> PULL_READ.
- PULL_READ:
  - Drives mem_req=1, mem_we=0, mem_addr={STACK_PAGE, sp_value}.
  - On an edge with mem_ready=1, mem_rdata is stored: 1st byte -> pull_data[7:0], 2nd -> [15:8], 3rd -> [23:16].
  - If more bytes remain, sp_inc=1 in that same cycle. After the last byte -> DONE, with no sp_inc.
  - Resulting order: RTS gives [7:0]=PCL, [15:8]=PCH; RTI gives [7:0]=P.
  - mem_ready=0: hold; sp_inc=0.
- DONE: done=1 for exactly one cycle, busy=0, then -> IDLE. A new start is accepted in the cycle after DONE.
- busy=1 in PUSH, PULL_INC, PULL_READ.
- Strobes:
  - sp_inc and sp_dec are never both 1.
  - Both are 0 outside PUSH/PULL_INC/PULL_READ.
- Wrap-around: mem_addr high byte is always STACK_PAGE. SP wrap (00->FF, FF->00) is owned by the stack pointer; this block applies no special case.
- Latency with mem_ready tied high:
  - push N bytes: N+1 cycles from start to done.
  - pull N bytes: N+2 cycles from start to done.

Test Plan:
- Push 1: sp=FF, start push count=1 push_data=0000A5, ready=1 -> one write 01FF<=A5 with sp_dec. done 2 cycles after start; sp ends FE.
- JSR push 2: sp=FD, push_data=00_12_34 -> writes 01FD<=12, then 01FC<=34. Two sp_dec; sp ends FB.
- RTI pull 3: sp=FA, memory 01FB=24, 01FC=34, 01FD=12 -> one idle sp_inc cycle, then reads at 01FB, 01FC, 01FD. pull_data=12_34_24; sp ends FD.
- Stall: during a 2-byte push, mem_ready=0 for 3 cycles on byte 1 -> address/data held, no sp_dec during the stall. done delayed by exactly 3 cycles.
- Wrap: sp=00, push count=1 -> write to 0100, sp becomes FF. A following pull count=1 reads 0100.
- Corner cases:
  - count=0 -> done one cycle after start, no mem_req, no strobes.
  - start pulsed while busy -> ignored.
  - reset asserted mid-pull -> all outputs 0 next cycle, no further sp_inc.
